// File: rtl/id_ex_regfile.sv
// Decode-to-execute stage: 32-entry register file with write-back port, immediate
// extraction, and the ID/EX pipeline register feeding the ALU stage.
module id_ex_regfile #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      InValid,
    input  logic [31:0]               Instruction,
    input  logic [8:0]                ControlSignals,
    input  logic [DATA_WIDTH-1:0]     PCIn,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      RegWriteWB,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegWB,
    input  logic [DATA_WIDTH-1:0]     WriteDataWB,
    output logic                      ExValid,
    output logic [8:0]                ExControl,
    output logic [DATA_WIDTH-1:0]     ExPC,
    output logic [DATA_WIDTH-1:0]     ExReadData1,
    output logic [DATA_WIDTH-1:0]     ExReadData2,
    output logic [DATA_WIDTH-1:0]     ExImm,
    output logic [REG_ADDR_WIDTH-1:0] ExRn,
    output logic [REG_ADDR_WIDTH-1:0] ExRm2,
    output logic [REG_ADDR_WIDTH-1:0] ExRd
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg = '1;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];

    logic [REG_ADDR_WIDTH-1:0] rn, rm2, rd;
    logic [DATA_WIDTH-1:0]     rdata1, rdata2, imm;
    logic                      wb_en;

    assign wb_en = RegWriteWB && (WriteRegWB != ZeroReg);

    assign rn  = Instruction[9:5];
    assign rd  = Instruction[4:0];
    assign rm2 = ControlSignals[8] ? Instruction[4:0] : Instruction[20:16];

    // XZR reads zero; a same-cycle write-back wins over the stale array entry.
    function automatic logic [DATA_WIDTH-1:0] read_src(input logic [REG_ADDR_WIDTH-1:0] idx);
        if (idx == ZeroReg) begin
            return '0;
        end else if (wb_en && (WriteRegWB == idx)) begin
            return WriteDataWB;
        end else begin
            return regs_q[idx];
        end
    endfunction

    assign rdata1 = read_src(rn);
    assign rdata2 = read_src(rm2);

    always_comb begin
        imm = '0;
        if (Instruction[31:26] == 6'b000101) begin
            imm = {{(DATA_WIDTH-26){Instruction[25]}}, Instruction[25:0]};
        end else if (Instruction[31:25] == 7'b1011010) begin
            imm = {{(DATA_WIDTH-19){Instruction[23]}}, Instruction[23:5]};
        end else if ((Instruction[31:21] == 11'b11111000010) ||
                     (Instruction[31:21] == 11'b11111000000)) begin
            imm = {{(DATA_WIDTH-9){Instruction[20]}}, Instruction[20:12]};
        end else if ((Instruction[31:22] == 10'b1001000100) ||
                     (Instruction[31:22] == 10'b1101000100)) begin
            imm = {{(DATA_WIDTH-12){1'b0}}, Instruction[21:10]};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[WriteRegWB] <= WriteDataWB;
        end
    end

    logic                      ex_valid_q;
    logic [8:0]                ex_control_q;
    logic [DATA_WIDTH-1:0]     ex_pc_q, ex_rdata1_q, ex_rdata2_q, ex_imm_q;
    logic [REG_ADDR_WIDTH-1:0] ex_rn_q, ex_rm2_q, ex_rd_q;

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            ex_valid_q   <= 1'b0;
            ex_control_q <= '0;
            ex_pc_q      <= '0;
            ex_rdata1_q  <= '0;
            ex_rdata2_q  <= '0;
            ex_imm_q     <= '0;
            ex_rn_q      <= '0;
            ex_rm2_q     <= '0;
            ex_rd_q      <= '0;
        end else if (!Stall) begin
            ex_valid_q   <= InValid;
            // A bubble must never carry side-effecting control bits.
            ex_control_q <= InValid ? ControlSignals : 9'd0;
            ex_pc_q      <= PCIn;
            ex_rdata1_q  <= rdata1;
            ex_rdata2_q  <= rdata2;
            ex_imm_q     <= imm;
            ex_rn_q      <= rn;
            ex_rm2_q     <= rm2;
            ex_rd_q      <= rd;
        end
    end

    assign ExValid     = ex_valid_q;
    assign ExControl   = ex_control_q;
    assign ExPC        = ex_pc_q;
    assign ExReadData1 = ex_rdata1_q;
    assign ExReadData2 = ex_rdata2_q;
    assign ExImm       = ex_imm_q;
    assign ExRn        = ex_rn_q;
    assign ExRm2       = ex_rm2_q;
    assign ExRd        = ex_rd_q;

endmodule

// File: doc/id_ex_regfile.md
Name: id_ex_regfile

Overview:
- Decode-to-execute stage directly downstream of the PC/instruction-memory/decode block.
- Consumes the 32-bit LEGv8 instruction, the 9-bit ControlSignals bundle and the instruction's PC.
- Reads the 32x64 register file, sign/zero-extends the immediate, and registers everything into an ID/EX pipeline register for the ALU stage.
- Also owns the register-file write-back port.

Parameters:
DATA_WIDTH, 64, register and PC width
REG_ADDR_WIDTH, 5, register index width (32 registers)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
InValid  input  1  instruction/control/PC inputs valid this cycle
Instruction  input  32  fetched instruction word
ControlSignals  input  9  [8]Reg2Loc [7]ALUSrc [6]MemtoReg [5]RegWrite [4]MemRead [3]MemWrite [2]Branch [1:0]ALUOp
PCIn  input  64  PC of Instruction
Stall  input  1  hold ID/EX contents
Flush  input  1  load bubble into ID/EX
RegWriteWB  input  1  write-back enable
WriteRegWB  input  5  write-back register index
WriteDataWB  input  64  write-back data
ExValid  output  1  ID/EX entry valid
ExControl  output  9  registered ControlSignals
ExPC  output  64  registered PCIn
ExReadData1  output  64  value of Rn
ExReadData2  output  64  value of Rm or Rt
ExImm  output  64  extended immediate
ExRn, ExRm2, ExRd  output  5 each  registered Rn, selected second source index, Rd (for forwarding)

Behaviour:
- Reset is synchronous, active-high, and takes priority over all other inputs.
  - On a reset edge, all 32 registers are cleared to 0.
  - On a reset edge, every output is cleared to 0; ExValid=0.
- Field decode:
  - Rn=Instruction[9:5], Rd=Instruction[4:0].
  - Second source = Instruction[20:16] (Rm) when Reg2Loc=0; Instruction[4:0] (Rt) when Reg2Loc=1.
- Register file:
  - X31 (XZR) always reads 0.
  - Writes to index 31 are discarded.
  - A write happens on the rising edge when RegWriteWB=1 and Reset=0.
  - Writes are independent of Stall/Flush.
- Write-first bypass:
  - If RegWriteWB=1, WriteRegWB!=31, and WriteRegWB equals a source index in the same cycle, the captured ExReadData* is WriteDataWB, not the stale array value.
- Immediate selection (first match wins):
  - Instruction[31:26]=000101 (B): sign-extend Instruction[25:0].
  - Instruction[31:25]=1011010 (CBZ/CBNZ): sign-extend Instruction[23:5].
  - Instruction[31:21]=11111000010 or 11111000000 (LDUR/STUR): sign-extend Instruction[20:12].
  - Instruction[31:22]=1001000100 (ADDI) or 1101000100 (SUBI): zero-extend Instruction[21:10].
  - Otherwise: 0.
- ID/EX update per edge (priority Reset > Flush > Stall > load):
  - Flush: ExValid=0, ExControl=0, other outputs don't-care but driven 0.
  - Stall: all outputs hold their values.
  - Load: capture all decoded values; ExValid=InValid.
  - When InValid=0, ExControl captures 0 so a bubble never asserts RegWrite/MemWrite/Branch.
- Latency: 1 cycle from inputs to Ex* outputs. No combinational path from inputs to outputs.
- Stall with write-back to a captured source register:
  - The held ExReadData is not refreshed.
  - Forwarding is the EX stage's responsibility via ExRn/ExRm2.
- Reset mid-operation:
  - A pending write-back in the reset cycle is dropped.
  - The register keeps 0.

Test Plan:
1. Reset, then WB write X1=0x5, X2=0xA. Then issue ADD X3,X1,X2 (0x8B020023, ctrl 0x022, InValid=1) -> next edge: ExReadData1=5, ExReadData2=0xA, ExRd=3, ExValid=1, ExControl=0x022.
2. Same cycle: WB X4=0x1234 plus instruction reading X4 as Rn -> ExReadData1=0x1234 (bypass). Then a WB write to X31=0xFF followed by a read of X31 -> 0.
3. LDUR X5,[X1,#-8] (Instruction[20:12]=0x1F8) -> ExImm=0xFFFFFFFFFFFFFFF8.
   - ADDI #4095 -> ExImm=0xFFF.
   - CBZ imm19=0x7FFFF -> ExImm=all ones.
   - B imm26=0x0000010 -> ExImm=0x10.
4. STUR with Reg2Loc=1, Rt=X2 -> ExRm2=2, ExReadData2=0xA.
5. Load instruction A.
   - Stall=1 for 2 cycles while the inputs change to B -> outputs still show A.
   - Stall=0 -> outputs show B.
   - Flush=1 together with Stall=1 -> ExValid=0, ExControl=0.
6. Registers hold nonzero values; assert Reset for 1 cycle together with RegWriteWB to X7 -> all Ex* outputs=0, and a subsequent read of X7=0.
